// File: rtl/filt_ppi_pkg.sv
// Shared constants, coefficient table and FSM encoding for the polyphase
// interpolator MAC (filt_ppi_mac). The prototype filter is symmetric, so only
// the first ceil(N/2) taps are stored; coeff_at() expands them to the full
// zero-padded length c_col*L.
package filt_ppi_pkg;

  localparam int c_idata_width   = 8;
  localparam int c_interp_factor = 4;
  localparam int c_coeff_length  = 17;
  localparam int c_coeff_width   = 8;

  localparam int c_col        = (c_coeff_length + c_interp_factor - 1) / c_interp_factor;
  localparam int c_prod_width = c_idata_width + c_coeff_width;
  localparam int c_sum_width  = c_prod_width + c_col;

  localparam int c_half  = (c_coeff_length + 1) / 2;
  localparam int c_idx_w = $clog2(c_half);

  typedef logic signed [c_coeff_width-1:0] coeff_t;

  // First half (including centre tap) of the symmetric low-pass prototype.
  localparam coeff_t c_coeff [c_half] = '{
    8'sd1, -8'sd2, -8'sd4, 8'sd0, 8'sd9, 8'sd20, 8'sd33, 8'sd44, 8'sd48
  };

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Full-length tap h[i]: mirrored above the centre, zero past the end.
  function automatic coeff_t coeff_at(input int i);
    int j;
    if (i < 0 || i >= c_coeff_length) return '0;
    j = (i < c_half) ? i : (c_coeff_length - 1 - i);
    return c_coeff[c_idx_w'(j)];
  endfunction

endpackage

// File: rtl/filt_ppi_phase_dot.sv
// Combinational dot product of the delay-line taps with one polyphase
// coefficient column: y = sum_k h[k*L + ph] * taps[k], full precision.
module filt_ppi_phase_dot
  import filt_ppi_pkg::*;
#(
  parameter int gp_idata_width   = c_idata_width,
  parameter int gp_interp_factor = c_interp_factor,
  parameter int gp_coeff_length  = c_coeff_length,
  parameter int gp_coeff_width   = c_coeff_width,
  parameter int gp_odata_width   = gp_idata_width + gp_coeff_width +
                                   ((gp_coeff_length + gp_interp_factor - 1) / gp_interp_factor)
) (
  input  logic signed [gp_idata_width-1:0] taps [(gp_coeff_length + gp_interp_factor - 1) / gp_interp_factor],
  input  logic [((gp_interp_factor > 1) ? $clog2(gp_interp_factor) : 1)-1:0] ph,
  output logic signed [gp_odata_width-1:0] y
);

  localparam int c_taps = (gp_coeff_length + gp_interp_factor - 1) / gp_interp_factor;
  localparam int c_pw   = gp_idata_width + gp_coeff_width;

  // Coefficient at full-filter index i, resized to the configured width.
  function automatic logic signed [gp_coeff_width-1:0] coef_sel(input int i);
    return gp_coeff_width'(coeff_at(i));
  endfunction

  // Exact sign extension of one product to the accumulator width.
  function automatic logic signed [gp_odata_width-1:0] sext_sum(input logic signed [c_pw-1:0] p);
    return gp_odata_width'(p);
  endfunction

  logic signed [c_pw-1:0]           tap_ext;
  logic signed [c_pw-1:0]           coef_ext;
  logic signed [c_pw-1:0]           prod;
  logic signed [gp_odata_width-1:0] acc;

  // Multiply each tap by its phase coefficient and accumulate.
  always_comb begin
    tap_ext  = '0;
    coef_ext = '0;
    prod     = '0;
    acc      = '0;
    for (int k = 0; k < c_taps; k++) begin
      tap_ext  = c_pw'(taps[k]);
      coef_ext = c_pw'(coef_sel(k * gp_interp_factor + int'(ph)));
      prod     = tap_ext * coef_ext;
      acc      = acc + sext_sum(prod);
    end
    y = acc;
  end

endmodule

// File: rtl/filt_ppi_mac.sv
// Polyphase interpolator MAC: one input sample in, gp_interp_factor output
// phases out, each a polyphase branch of the symmetric prototype FIR.
// Optional macro FILT_PPI_PHASE_OUT_EN adds the o_phase output port.
module filt_ppi_mac
  import filt_ppi_pkg::*;
#(
  parameter int gp_idata_width   = c_idata_width,
  parameter int gp_interp_factor = c_interp_factor,
  parameter int gp_coeff_length  = c_coeff_length,
  parameter int gp_coeff_width   = c_coeff_width,
  parameter int gp_odata_width   = gp_idata_width + gp_coeff_width +
                                   ((gp_coeff_length + gp_interp_factor - 1) / gp_interp_factor)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_an,
  input  logic                             i_ena,
  input  logic signed [gp_idata_width-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic signed [gp_odata_width-1:0] o_data,
  output logic                             o_valid,
  input  logic                             i_ready
`ifdef FILT_PPI_PHASE_OUT_EN
  ,
  output logic [((gp_interp_factor > 1) ? $clog2(gp_interp_factor) : 1)-1:0] o_phase
`endif
);

  localparam int c_taps = (gp_coeff_length + gp_interp_factor - 1) / gp_interp_factor;
  localparam int c_phw  = (gp_interp_factor > 1) ? $clog2(gp_interp_factor) : 1;
  localparam logic [c_phw-1:0] c_last = c_phw'(gp_interp_factor - 1);

  logic signed [gp_idata_width-1:0] x_p0  [c_taps];
  logic signed [gp_idata_width-1:0] x_nxt [c_taps];
  state_t                           state;
  logic [c_phw-1:0]                 ph;
  logic [c_phw-1:0]                 ph_nxt;
  logic signed [gp_odata_width-1:0] y_dot;
  logic signed [gp_odata_width-1:0] y_p1;
  logic                             vld_p1;
  logic                             last;
  logic                             accept;
  logic                             advance;

  assign last    = (ph == c_last);
  // Ready is combinational from i_ready so a new sample can be taken on the
  // same cycle the final phase is consumed, giving gapless full-rate output.
  assign o_ready = i_rst_an & i_ena &
                   ((state == IDLE) | ((state == EMIT) & last & i_ready));
  assign accept  = o_ready & i_valid;
  assign advance = i_rst_an & i_ena & (state == EMIT) & i_ready & ~last;

  // Next phase and post-shift delay line feed the dot product, so the output
  // register always captures the value belonging to the state being entered.
  always_comb begin
    ph_nxt = ph;
    x_nxt  = x_p0;
    if (accept) begin
      ph_nxt   = '0;
      x_nxt[0] = i_data;
      for (int k = 1; k < c_taps; k++) x_nxt[k] = x_p0[k-1];
    end else if (advance) begin
      ph_nxt = ph + c_phw'(1);
    end
  end

  filt_ppi_phase_dot #(
    .gp_idata_width  (gp_idata_width),
    .gp_interp_factor(gp_interp_factor),
    .gp_coeff_length (gp_coeff_length),
    .gp_coeff_width  (gp_coeff_width),
    .gp_odata_width  (gp_odata_width)
  ) u_dot (
    .taps(x_nxt),
    .ph  (ph_nxt),
    .y   (y_dot)
  );

  // Sample delay line: shifts only when a sample is accepted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      for (int k = 0; k < c_taps; k++) x_p0[k] <= '0;
    end else if (accept) begin
      x_p0 <= x_nxt;
    end
  end

  // Control FSM with phase counter and registered output sample.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      state  <= IDLE;
      ph     <= '0;
      y_p1   <= '0;
      vld_p1 <= 1'b0;
    end else if (i_ena) begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= EMIT;
            ph     <= ph_nxt;
            y_p1   <= y_dot;
            vld_p1 <= 1'b1;
          end
        end
        EMIT: begin
          if (i_ready) begin
            if (accept || advance) begin
              ph   <= ph_nxt;
              y_p1 <= y_dot;
            end else begin
              state  <= IDLE;
              vld_p1 <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign o_data  = y_p1;
  assign o_valid = vld_p1;

`ifdef FILT_PPI_PHASE_OUT_EN
  logic [c_phw-1:0] phase_p1;

  // Phase index captured together with each new output sample.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      phase_p1 <= '0;
    end else if (accept || advance) begin
      phase_p1 <= ph_nxt;
    end
  end

  assign o_phase = phase_p1;
`endif

endmodule

// File: doc/filt_ppi_mac.md
Name: filt_ppi_mac

Overview:
Polyphase interpolator multiply-accumulate core, the interpolating counterpart of the filt_ppd decimator datapath. Accepts one input sample per handshake and produces gp_interp_factor output samples, one per output handshake. Each output is one polyphase branch of the symmetric FIR defined by the shared filt_coeff.v coefficient include. The block sits between a low-rate sample source and the high-rate DAC/upsampled chain.

Parameters:
gp_idata_width, 8, input sample width (signed)
gp_interp_factor, 4, interpolation factor L (≥2); number of output phases per input
gp_coeff_length, 17, prototype filter length N
gp_coeff_width, 8, coefficient width (signed)
gp_odata_width, gp_idata_width+gp_coeff_width+ceil(N/L), output width (signed, full precision)

Ports:
i_clk  in  1  rising-edge clock
i_rst_an  in  1  reset, synchronous, active-low
i_ena  in  1  synchronous active-high enable; low freezes all state
i_data  in  gp_idata_width  input sample, signed
i_valid  in  1  input sample valid
o_ready  out  1  block can accept i_data this cycle
o_data  out  gp_odata_width  output sample, signed
o_valid  out  1  o_data valid
i_ready  in  1  downstream accepts o_data

Behaviour:
- Constants: c_col = ceil(N/L) taps per phase. Coefficient h[i] = c_coeff[i] for i<ceil(N/2); c_coeff[N-1-i] for ceil(N/2)≤i<N; 0 for N≤i<c_col*L.
- Delay line x[0..c_col-1], gp_idata_width each. On input accept (i_valid & o_ready & i_ena): x[0]←i_data, x[k]←x[k-1].
- Phase p output: y_p = Σ_{k=0..c_col-1} h[k*L+p]·x[k], using the delay line after the shift. Products are idata+coeff bits; the sum is sign-extended to gp_odata_width. No overflow is possible at the default width.
- FSM: IDLE, EMIT. Phase counter ph is clog2(L) bits.
  - IDLE: o_ready=1. Accept → EMIT, ph=0; o_data=y_0 registered; o_valid=1 on the next cycle. Latency is 1 cycle.
  - EMIT: o_data/o_valid are held stable while i_ready=0.
  - EMIT, on i_ready=1 with ph<L-1: ph+1, o_data=y_{ph+1}.
  - EMIT, on i_ready=1 with ph=L-1: if i_valid=1, accept the new sample, go to ph=0 with the new y_0, and stay in EMIT. Otherwise go to IDLE with o_valid=0.
- o_ready = i_ena & (state==IDLE | (state==EMIT & ph==L-1 & i_ready)). This is a combinational path from i_ready. Sustained throughput is one input per L cycles, with o_valid continuously high.
- i_ena=0: no state, counter, delay-line or output-register change. o_ready=0. o_valid holds its value.
- Reset (any time, including mid-burst): state=IDLE, ph=0, delay line=0, o_data=0, o_valid=0. An in-flight burst is discarded. o_ready=0 while reset is asserted and 1 on the first enabled cycle after release.
- i_valid while o_ready=0 is ignored; the source must hold it.

Optional Feature:
FILT_PPI_PHASE_OUT_EN.
- Defined: adds output port o_phase (clog2(L) bits), registered alongside o_data, equal to the phase index p of the current o_data. Reset value 0.
- Undefined: the port and its register are absent. Behaviour is otherwise identical.

Decomposition:
- Package filt_ppi_pkg:
  - localparams c_col, c_prod_width, c_sum_width
  - function coeff_at(i) implementing the symmetric/zero-pad index rule over c_coeff
  - FSM state encoding (IDLE=0, EMIT=1)
- Sub-module filt_ppi_phase_dot: combinational dot product of the c_col delay-line taps with the phase-selected coefficient column, given phase index ph. The top level holds the FSM, delay line, counter and output register.

Test Plan:
- Impulse: i_data=1 then 5 zeros, i_ready=1 → 20 outputs equal h[0..16],0,0,0 in order, then zeros; first o_valid 1 cycle after accept.
- DC: i_data=+1 held for ≥c_col inputs → steady-state phase p outputs = Σ_k h[k*L+p]. Same with i_data=-128 → -128·Σ_k h[k*L+p] with exact sign extension, no overflow.
- Full rate: i_valid=1, i_ready=1 continuously → o_valid never drops after the first output; o_ready pulses exactly every 4 cycles, coincident with ph=3.
- Backpressure: i_ready=0 for 3 cycles while ph=2 → o_data, o_valid (and o_phase) stable; o_ready=0; no input accepted; resumes with ph=3.
- Freeze/reset: i_ena=0 for 5 cycles mid-burst → all outputs stable, o_ready=0. Sync reset asserted at ph=1 → next cycle o_valid=0, o_data=0, delay line cleared; a subsequent impulse reproduces the first test exactly.
